tlc_phase_ctrl: RTL and testbench

- Traffic-light phase controller for a two-road intersection: main road, side road and a pedestrian crossing.
- Sequences light phases and times each phase with an internal seconds timer (prescaler plus seconds counter, compared against a per-phase duration).
- Latches vehicle-sensor and pedestrian requests, and provides a maintenance flash mode.
- Sits between the board inputs (sensors, buttons) and the lamp drivers.

---
 rtl/tlc_pkg.sv | 27 ++
 rtl/tlc_sec_timer.sv | 40 ++++
 rtl/tlc_phase_ctrl.sv | 149 ++++++++++++++
 tb/tb_tlc_phase_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types and lamp encodings for the traffic-light phase controller.
// Lamp vectors are {red,yellow,green}.
package tlc_pkg;

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    ALLRED_1 = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_Y   = 3'd4,
    ALLRED_2 = 3'd5,
    WALK     = 3'd6,
    FLASH    = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [7:0] DUR_FLASH = 8'hff;

  function automatic bit dur_legal(input int d);
    return (d >= 1) && (d <= 255);
  endfunction

endpackage

// File: rtl/tlc_sec_timer.sv
// Phase timer: free-running prescaler plus saturating seconds counter.
// done is raised in the final cycle so the FSM leaves after dur*CLK_HZ cycles.
module tlc_sec_timer #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic [7:0] dur,
  output logic       done,
  output logic       tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] pre_q;
  logic [7:0]    sec_q;

  assign tick = (pre_q == PRE_MAX);

  // Lookahead on the last tick lets the state change land on the boundary.
  assign done = (sec_q == dur) ||
                (tick && ((sec_q + 8'd1) == dur));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      sec_q <= '0;
    end else if (restart) begin
      pre_q <= '0;
      sec_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      if (tick && (sec_q < dur))
        sec_q <= sec_q + 8'd1;
    end
  end

endmodule

// File: rtl/tlc_phase_ctrl.sv
// Two-road intersection phase controller with pedestrian phase,
// request latching and maintenance flash mode.
module tlc_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int T_MAIN_G = 10,
  parameter int T_SIDE_G = 6,
  parameter int T_YEL    = 3,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       side_car,
  input  logic       ped_req,
  input  logic       maint,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       walk,
  output logic [2:0] phase
);

  if (!(dur_legal(T_MAIN_G) && dur_legal(T_SIDE_G) &&
        dur_legal(T_YEL) && dur_legal(T_ALLRED) &&
        dur_legal(T_WALK))) begin : g_bad_dur
    $error("tlc_phase_ctrl: durations must be 1..255");
  end

  if (CLK_HZ < 1) begin : g_bad_clk
    $error("tlc_phase_ctrl: CLK_HZ must be >= 1");
  end

  state_t     state_q;
  state_t     state_d;
  logic       side_pend_q;
  logic       ped_pend_q;
  logic       flash_on_q;
  logic [7:0] dur;
  logic       done;
  logic       tick;
  logic       restart;

  tlc_sec_timer #(
    .CLK_HZ (CLK_HZ)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .dur     (dur),
    .done    (done),
    .tick    (tick)
  );

  always_comb begin
    dur = 8'(T_ALLRED);
    unique case (state_q)
      MAIN_G:   dur = 8'(T_MAIN_G);
      MAIN_Y:   dur = 8'(T_YEL);
      ALLRED_1: dur = 8'(T_ALLRED);
      SIDE_G:   dur = 8'(T_SIDE_G);
      SIDE_Y:   dur = 8'(T_YEL);
      ALLRED_2: dur = 8'(T_ALLRED);
      WALK:     dur = 8'(T_WALK);
      FLASH:    dur = DUR_FLASH;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (maint) begin
      state_d = FLASH;
    end else begin
      unique case (state_q)
        MAIN_G:
          if (done && (side_pend_q || ped_pend_q))
            state_d = MAIN_Y;
        MAIN_Y:
          if (done) state_d = ALLRED_1;
        ALLRED_1:
          if (done)
            state_d = side_pend_q ? SIDE_G :
                      ped_pend_q  ? WALK   : MAIN_G;
        SIDE_G:
          if (done) state_d = SIDE_Y;
        SIDE_Y:
          if (done) state_d = ALLRED_2;
        ALLRED_2:
          if (done)
            state_d = ped_pend_q ? WALK : MAIN_G;
        WALK:
          if (done) state_d = ALLRED_2;
        FLASH:
          state_d = ALLRED_2;
      endcase
    end
  end

  assign restart = (state_d != state_q);

  logic side_set;
  logic side_clr;
  logic ped_set;
  logic ped_clr;

  assign side_set = side_car && (state_q != SIDE_G);
  assign side_clr = restart && (state_d == SIDE_G);
  assign ped_set  = ped_req && (state_q != WALK);
  assign ped_clr  = restart && (state_d == WALK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ALLRED_2;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      flash_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_pend_q <= side_set | (side_pend_q & ~side_clr);
      ped_pend_q  <= ped_set | (ped_pend_q & ~ped_clr);
      if (restart && (state_d == FLASH))
        flash_on_q <= 1'b1;
      else if ((state_q == FLASH) && tick)
        flash_on_q <= ~flash_on_q;
    end
  end

  always_comb begin
    main_lamp = LAMP_R;
    side_lamp = LAMP_R;
    walk      = 1'b0;
    unique case (state_q)
      MAIN_G:   main_lamp = LAMP_G;
      MAIN_Y:   main_lamp = LAMP_Y;
      ALLRED_1: ;
      SIDE_G:   side_lamp = LAMP_G;
      SIDE_Y:   side_lamp = LAMP_Y;
      ALLRED_2: ;
      WALK:     walk = 1'b1;
      FLASH: begin
        main_lamp = flash_on_q ? LAMP_Y : LAMP_OFF;
        side_lamp = flash_on_q ? LAMP_Y : LAMP_OFF;
      end
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_tlc_phase_ctrl.sv
// Directed bench for tlc_phase_ctrl with a 4-cycle second
// and short phase durations.
module tb_tlc_phase_ctrl;

  localparam logic [2:0] P_MAIN_G = 3'd0;
  localparam logic [2:0] P_MAIN_Y = 3'd1;
  localparam logic [2:0] P_AR1    = 3'd2;
  localparam logic [2:0] P_SIDE_G = 3'd3;
  localparam logic [2:0] P_SIDE_Y = 3'd4;
  localparam logic [2:0] P_AR2    = 3'd5;
  localparam logic [2:0] P_WALK   = 3'd6;
  localparam logic [2:0] P_FLASH  = 3'd7;

  logic       clk;
  logic       reset_n;
  logic       side_car;
  logic       ped_req;
  logic       maint;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk;
  logic [2:0] phase;

  int total;
  int bad;

  tlc_phase_ctrl #(
    .CLK_HZ   (4),
    .T_MAIN_G (3),
    .T_SIDE_G (2),
    .T_YEL    (1),
    .T_ALLRED (1),
    .T_WALK   (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .side_car  (side_car),
    .ped_req   (ped_req),
    .maint     (maint),
    .main_lamp (main_lamp),
    .side_lamp (side_lamp),
    .walk      (walk),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // {main, side, walk} expected for each non-flash phase
  function automatic logic [6:0] exp_out(input logic [2:0] p);
    case (p)
      P_MAIN_G: return {3'b001, 3'b100, 1'b0};
      P_MAIN_Y: return {3'b010, 3'b100, 1'b0};
      P_SIDE_G: return {3'b100, 3'b001, 1'b0};
      P_SIDE_Y: return {3'b100, 3'b010, 1'b0};
      P_WALK:   return {3'b100, 3'b100, 1'b1};
      default:  return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic run_phase(input logic [2:0] p,
                           input int n,
                           input string tag);
    logic [6:0] e;
    e = exp_out(p);
    for (int i = 0; i < n; i++) begin
      check({tag, "/phase"}, 8'(phase), 8'(p));
      check({tag, "/main"}, 8'(main_lamp), 8'(e[6:4]));
      check({tag, "/side"}, 8'(side_lamp), 8'(e[3:1]));
      check({tag, "/walk"}, 8'(walk), 8'(e[0]));
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    @(negedge clk);
    check({tag, "/rst_phase"}, 8'(phase), 8'(P_AR2));
    check({tag, "/rst_main"}, 8'(main_lamp), 8'b100);
    check({tag, "/rst_side"}, 8'(side_lamp), 8'b100);
    check({tag, "/rst_walk"}, 8'(walk), 8'd0);
    reset_n = 1'b1;
    run_phase(P_AR2, 4, {tag, "/ar2"});
  endtask

  // 12-cycle main green with optional requests pulsed in its 2nd cycle
  task automatic main_g_with(input logic sc, input logic pr,
                             input string tag);
    run_phase(P_MAIN_G, 1, tag);
    side_car = sc;
    ped_req  = pr;
    run_phase(P_MAIN_G, 1, tag);
    side_car = 1'b0;
    ped_req  = 1'b0;
    run_phase(P_MAIN_G, 10, tag);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    side_car = 1'b0;
    ped_req  = 1'b0;
    maint    = 1'b0;
    @(negedge clk);

    do_reset("idle");
    run_phase(P_MAIN_G, 100, "idle_hold");

    do_reset("side");
    main_g_with(1'b1, 1'b0, "side_mg");
    run_phase(P_MAIN_Y, 4, "side_my");
    run_phase(P_AR1, 4, "side_ar1");
    run_phase(P_SIDE_G, 8, "side_sg");
    run_phase(P_SIDE_Y, 4, "side_sy");
    run_phase(P_AR2, 4, "side_ar2");
    run_phase(P_MAIN_G, 20, "side_back");

    do_reset("ped");
    main_g_with(1'b0, 1'b1, "ped_mg");
    run_phase(P_MAIN_Y, 4, "ped_my");
    run_phase(P_AR1, 4, "ped_ar1");
    run_phase(P_WALK, 8, "ped_walk");
    run_phase(P_AR2, 4, "ped_ar2");
    run_phase(P_MAIN_G, 10, "ped_back");

    do_reset("both");
    main_g_with(1'b1, 1'b1, "both_mg");
    run_phase(P_MAIN_Y, 4, "both_my");
    run_phase(P_AR1, 4, "both_ar1");
    run_phase(P_SIDE_G, 8, "both_sg");
    run_phase(P_SIDE_Y, 4, "both_sy");
    run_phase(P_AR2, 4, "both_ar2a");
    run_phase(P_WALK, 8, "both_walk");
    run_phase(P_AR2, 4, "both_ar2b");
    run_phase(P_MAIN_G, 10, "both_back");

    do_reset("mnt");
    main_g_with(1'b1, 1'b1, "mnt_mg");
    run_phase(P_MAIN_Y, 4, "mnt_my");
    run_phase(P_AR1, 4, "mnt_ar1");
    run_phase(P_SIDE_G, 3, "mnt_sg");
    maint = 1'b1;
    run_phase(P_SIDE_G, 1, "mnt_sg_last");
    for (int i = 0; i < 13; i++) begin
      logic [2:0] y;
      y = (((i / 4) % 2) == 0) ? 3'b010 : 3'b000;
      check("flash/phase", 8'(phase), 8'(P_FLASH));
      check("flash/main", 8'(main_lamp), 8'(y));
      check("flash/side", 8'(side_lamp), 8'(y));
      check("flash/walk", 8'(walk), 8'd0);
      if (i == 12) maint = 1'b0;
      @(negedge clk);
    end
    run_phase(P_AR2, 4, "mnt_ar2a");
    run_phase(P_WALK, 8, "mnt_walk");
    run_phase(P_AR2, 4, "mnt_ar2b");
    run_phase(P_MAIN_G, 10, "mnt_back");

    do_reset("arst");
    main_g_with(1'b0, 1'b1, "arst_mg");
    run_phase(P_MAIN_Y, 4, "arst_my");
    run_phase(P_AR1, 4, "arst_ar1");
    run_phase(P_WALK, 2, "arst_walk");
    side_car = 1'b1;
    run_phase(P_WALK, 1, "arst_walk_sc");
    side_car = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst/phase", 8'(phase), 8'(P_AR2));
    check("arst/main", 8'(main_lamp), 8'b100);
    check("arst/side", 8'(side_lamp), 8'b100);
    check("arst/walk", 8'(walk), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_phase(P_AR2, 4, "arst_ar2");
    run_phase(P_MAIN_G, 30, "arst_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
